// File: rtl/airlock_pkg.sv
// Shared airlock definitions: state encoding and default sizing constants.
// Used by both the arrival and departure airlock controllers.
package airlock_pkg;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_WAIT      = 4'd1,
      S_EVAC      = 4'd2,
      S_OPEN_OUT  = 4'd3,
      S_CLOSE_OUT = 4'd4,
      S_PRES      = 4'd5,
      S_OPEN_IN   = 4'd6,
      S_CLOSE_IN  = 4'd7,
      S_DONE      = 4'd8
   } state_t;

   localparam int DEF_GARAGE_SIZE = 3;
   localparam int DEF_WAIT_CYCLES = 4;
   localparam int DEF_TIMER_W     = 3;
   localparam int DEF_CNT_W       = 3;

endpackage

// File: rtl/airlock_timer.sv
// Loadable down-counter for airlock dwell timing; done is high while the count is zero.
module airlock_timer #(
   parameter int TIMER_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               dec,
   input  logic [TIMER_W-1:0] value,
   output logic               done
);

   logic [TIMER_W-1:0] r_count;

   // Load wins over decrement; the count saturates at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= value;
      end else if (dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign done = (r_count == '0);

endmodule

// File: rtl/arriving_ctrl.sv
// Arrival airlock controller: admits one vehicle from outside into the garage (Moore FSM).
// Optional abort in WAIT/EVAC is enabled by defining ARRIVING_ABORT_EN.
module arriving_ctrl
   import airlock_pkg::*;
#(
   parameter int GARAGE_SIZE = DEF_GARAGE_SIZE,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
   parameter int TIMER_W     = DEF_TIMER_W,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             arrive_req,
   input  logic             departing,
   input  logic [CNT_W-1:0] garage_count,
   input  logic             evacuated,
   input  logic             pressurized,
   input  logic             outer_door,
   input  logic             inner_door,
   input  logic             vehicle_in,
   input  logic             abort,
   output logic             arriving,
   output logic             evac_cmd,
   output logic             pres_cmd,
   output logic             outer_open,
   output logic             inner_open,
   output logic             arrived,
   output logic [3:0]       debug_state
);

   state_t r_state;
   state_t w_nextState;
   logic   w_timerLoad;
   logic   w_timerDec;
   logic   w_timerDone;
   logic   w_admit;

   airlock_timer #(.TIMER_W(TIMER_W)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (w_timerLoad),
      .dec   (w_timerDec),
      .value (TIMER_W'(WAIT_CYCLES - 1)),
      .done  (w_timerDone)
   );

   assign w_admit = arrive_req && !departing && (garage_count < CNT_W'(GARAGE_SIZE));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Sensor waits have no timeout: each state holds until its condition appears.
   always_comb begin
      w_nextState = r_state;
      w_timerLoad = 1'b0;
      w_timerDec  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_admit) begin
               w_nextState = S_WAIT;
               w_timerLoad = 1'b1;
            end
         end
         S_WAIT: begin
            if (w_timerDone) begin
               w_nextState = S_EVAC;
            end else begin
               w_timerDec = 1'b1;
            end
         end
         S_EVAC:      if (evacuated)                 w_nextState = S_OPEN_OUT;
         S_OPEN_OUT:  if (outer_door && vehicle_in)  w_nextState = S_CLOSE_OUT;
         S_CLOSE_OUT: if (!outer_door)               w_nextState = S_PRES;
         S_PRES:      if (pressurized)               w_nextState = S_OPEN_IN;
         S_OPEN_IN:   if (inner_door && !vehicle_in) w_nextState = S_CLOSE_IN;
         S_CLOSE_IN:  if (!inner_door)               w_nextState = S_DONE;
         S_DONE:      w_nextState = S_IDLE;
         default:     w_nextState = S_IDLE;
      endcase
`ifdef ARRIVING_ABORT_EN
      // Abort is only honoured before any door has opened.
      if (abort && ((r_state == S_WAIT) || (r_state == S_EVAC))) begin
         w_nextState = S_IDLE;
      end
`endif
   end

`ifndef ARRIVING_ABORT_EN
   logic w_abortUnused;
   assign w_abortUnused = abort;
`endif

   always_comb begin
      evac_cmd   = 1'b0;
      pres_cmd   = 1'b0;
      outer_open = 1'b0;
      inner_open = 1'b0;
      arrived    = 1'b0;
      case (r_state)
         S_EVAC:     evac_cmd   = 1'b1;
         S_OPEN_OUT: outer_open = 1'b1;
         S_PRES:     pres_cmd   = 1'b1;
         S_OPEN_IN:  inner_open = 1'b1;
         S_DONE:     arrived    = 1'b1;
         default:    ;
      endcase
   end

   assign arriving    = (r_state != S_IDLE);
   assign debug_state = r_state;

endmodule

// File: tb/tb_arriving_ctrl.sv
// Self-checking bench for arriving_ctrl: directed scenarios plus randomized traffic
// compared against a phase-level reference model of the airlock sequence.
module tb_arriving_ctrl;

   localparam int GARAGE_SIZE = 3;
   localparam int WAIT_CYCLES = 4;
   localparam int CNT_W       = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             arrive_req = 1'b0;
   logic             departing = 1'b0;
   logic [CNT_W-1:0] garage_count = '0;
   logic             evacuated = 1'b0;
   logic             pressurized = 1'b0;
   logic             outer_door = 1'b0;
   logic             inner_door = 1'b0;
   logic             vehicle_in = 1'b0;
   logic             abort = 1'b0;
   logic             arriving, evac_cmd, pres_cmd, outer_open, inner_open, arrived;
   logic [3:0]       debug_state;

   int nCompared   = 0;
   int nMismatched = 0;

   // Reference model: phase of the admission sequence, cycles spent in it, WAIT elapsed count
   int mPhase   = 0;
   int mAge     = 0;
   int mWaitCnt = 0;
   int cycleNum = 0;
   int holdPhase = -1;
   logic wantArrive = 1'b0;

   arriving_ctrl #(
      .GARAGE_SIZE (GARAGE_SIZE),
      .WAIT_CYCLES (WAIT_CYCLES),
      .TIMER_W     (3),
      .CNT_W       (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .arrive_req   (arrive_req),
      .departing    (departing),
      .garage_count (garage_count),
      .evacuated    (evacuated),
      .pressurized  (pressurized),
      .outer_door   (outer_door),
      .inner_door   (inner_door),
      .vehicle_in   (vehicle_in),
      .abort        (abort),
      .arriving     (arriving),
      .evac_cmd     (evac_cmd),
      .pres_cmd     (pres_cmd),
      .outer_open   (outer_open),
      .inner_open   (inner_open),
      .arrived      (arrived),
      .debug_state  (debug_state)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cycleNum);
      end
   endtask

   // Next phase from the sequence rules, given the inputs currently driven.
   function automatic int modelNext(int phase, int waitCnt);
      int nxt;
      nxt = phase;
      if (rst) return 0;
      if (phase == 0) begin
         if (arrive_req && !departing && (int'(garage_count) < GARAGE_SIZE)) nxt = 1;
      end else if (phase == 1) begin
         if (waitCnt + 1 >= WAIT_CYCLES) nxt = 2;
      end else if (phase == 2) begin
         if (evacuated) nxt = 3;
      end else if (phase == 3) begin
         if (outer_door && vehicle_in) nxt = 4;
      end else if (phase == 4) begin
         if (!outer_door) nxt = 5;
      end else if (phase == 5) begin
         if (pressurized) nxt = 6;
      end else if (phase == 6) begin
         if (inner_door && !vehicle_in) nxt = 7;
      end else if (phase == 7) begin
         if (!inner_door) nxt = 8;
      end else begin
         nxt = 0;
      end
`ifdef ARRIVING_ABORT_EN
      if (abort && (phase == 1 || phase == 2)) nxt = 0;
`endif
      return nxt;
   endfunction

   // One clock: model advances with the DUT, then every output is compared at the falling edge.
   task automatic applyStimulus();
      int nxt;
      nxt = modelNext(mPhase, mWaitCnt);
      @(posedge clk);
      if (nxt == 1 && mPhase == 1) mWaitCnt++;
      else mWaitCnt = 0;
      if (nxt == mPhase) mAge++;
      else mAge = 0;
      mPhase = nxt;
      cycleNum++;
      @(negedge clk);
      checkOutput("state",      debug_state, mPhase);
      checkOutput("arriving",   arriving,    mPhase != 0);
      checkOutput("evac_cmd",   evac_cmd,    mPhase == 2);
      checkOutput("outer_open", outer_open,  mPhase == 3);
      checkOutput("pres_cmd",   pres_cmd,    mPhase == 5);
      checkOutput("inner_open", inner_open,  mPhase == 6);
      checkOutput("arrived",    arrived,     mPhase == 8);
      checkOutput("doorExcl",   outer_open & inner_open, 0);
      checkOutput("pumpExcl",   evac_cmd & pres_cmd, 0);
   endtask

   // Sensors answer one cycle after the controller enters the state that asks for them.
   task automatic setLagSensors();
      logic late;
      late = (mAge >= 1) && (mPhase != holdPhase);
      arrive_req  = wantArrive && (mPhase == 0);
      evacuated   = (mPhase == 2) && late;
      pressurized = (mPhase == 5) && late;
      outer_door  = ((mPhase == 3) && late) || ((mPhase == 4) && !late);
      inner_door  = ((mPhase == 6) && late) || ((mPhase == 7) && !late);
      vehicle_in  = ((mPhase == 3) && late) || (mPhase == 4) || (mPhase == 5) || ((mPhase == 6) && !late);
   endtask

   task automatic runTo(input int target, input int budget);
      int n;
      n = 0;
      while (mPhase != target && n < budget) begin
         setLagSensors();
         applyStimulus();
         n++;
      end
      checkOutput("reachState", debug_state, target);
   endtask

   task automatic doReset();
      rst = 1'b1;
      abort = 1'b0;
      applyStimulus();
      rst = 1'b0;
   endtask

   initial begin
      int tWait, tEvac, nArrived;
      @(negedge clk);
      departing = 1'b0;
      garage_count = 3'd2;
      doReset();
      checkOutput("resetArriving", arriving, 0);

      // Sensors lag by a cycle; WAIT must last exactly WAIT_CYCLES cycles
      $display("[TB] lagged full sequence");
      wantArrive = 1'b1;
      tWait = -1; tEvac = -1; nArrived = 0;
      for (int i = 0; i < 200 && !(mPhase == 0 && tEvac >= 0); i++) begin
         setLagSensors();
         if (mPhase != 0) wantArrive = 1'b0;
         applyStimulus();
         if (debug_state == 4'd1 && tWait < 0) tWait = cycleNum;
         if (debug_state == 4'd2 && tEvac < 0) tEvac = cycleNum;
         if (arrived) nArrived++;
      end
      checkOutput("waitLength", tEvac - tWait, WAIT_CYCLES);
      checkOutput("arrivedCount", nArrived, 1);

      // Full garage or busy departure side keeps the controller idle
      $display("[TB] admission refusal");
      arrive_req = 1'b1; garage_count = 3'd3; departing = 1'b0;
      for (int i = 0; i < 20; i++) applyStimulus();
      checkOutput("fullIdle", arriving, 0);
      garage_count = 3'd0; departing = 1'b1;
      for (int i = 0; i < 20; i++) applyStimulus();
      checkOutput("departIdle", arriving, 0);
      arrive_req = 1'b0; departing = 1'b0; garage_count = 3'd2;

      // Vehicle never shows: OPEN_OUT holds, then proceeds once it does
      $display("[TB] open-outer hold");
      wantArrive = 1'b1;
      runTo(3, 40);
      wantArrive = 1'b0;
      outer_door = 1'b1; vehicle_in = 1'b0;
      for (int i = 0; i < 50; i++) applyStimulus();
      checkOutput("holdOuterOpen", outer_open, 1);
      vehicle_in = 1'b1;
      applyStimulus();
      checkOutput("holdRelease", debug_state, 4);

      // Reset mid-sequence returns to IDLE at once
      $display("[TB] reset in OPEN_OUT");
      doReset();
      wantArrive = 1'b1;
      runTo(3, 40);
      wantArrive = 1'b0;
      doReset();
      checkOutput("rstState", debug_state, 0);
      checkOutput("rstOuter", outer_open, 0);

`ifdef ARRIVING_ABORT_EN
      $display("[TB] abort behaviour");
      wantArrive = 1'b1;
      holdPhase = 2;
      runTo(2, 40);
      wantArrive = 1'b0;
      abort = 1'b1;
      setLagSensors();
      applyStimulus();
      abort = 1'b0;
      checkOutput("abortEvac", debug_state, 0);
      checkOutput("abortEvacCmd", evac_cmd, 0);
      holdPhase = 5;
      wantArrive = 1'b1;
      runTo(5, 60);
      wantArrive = 1'b0;
      abort = 1'b1;
      for (int i = 0; i < 3; i++) begin
         setLagSensors();
         applyStimulus();
      end
      abort = 1'b0;
      checkOutput("abortPresIgnored", debug_state, 5);
      holdPhase = -1;
      doReset();
`endif

      // Randomized traffic against the reference model
      $display("[TB] random traffic");
      for (int i = 0; i < 1500; i++) begin
         rst          = ($urandom_range(0, 99) == 0);
         arrive_req   = ($urandom_range(0, 9) < 7);
         departing    = ($urandom_range(0, 9) < 2);
         garage_count = CNT_W'($urandom_range(0, 4));
         evacuated    = $urandom_range(0, 1) != 0;
         pressurized  = $urandom_range(0, 1) != 0;
         outer_door   = $urandom_range(0, 1) != 0;
         inner_door   = $urandom_range(0, 1) != 0;
         vehicle_in   = $urandom_range(0, 1) != 0;
         abort        = ($urandom_range(0, 9) == 0);
         applyStimulus();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
